// File: rtl/wb_pkg.sv
// wb_pkg: shared types and load funct3 encodings for the writeback stage.
package wb_pkg;
    typedef enum logic [1:0] {
        RES_ALU       = 2'b00,
        RES_MEM       = 2'b01,
        RES_PC_PLUS   = 2'b10,
        RES_LUI_AUIPC = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: combinational load aligner and sign/zero extender.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    output logic [XLEN-1:0]  ext
);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] sxb, sxh, sxw, zxb, zxh, zxw;

    always_comb begin
        shifted = data >> {off, 3'b000};
        sxb     = XLEN'($signed(shifted[7:0]));
        sxh     = XLEN'($signed(shifted[15:0]));
        sxw     = XLEN'($signed(shifted[31:0]));
        zxb     = XLEN'(shifted[7:0]);
        zxh     = XLEN'(shifted[15:0]);
        zxw     = XLEN'(shifted[31:0]);
        case (funct3)
            F3_LB:   ext = sxb;
            F3_LH:   ext = sxh;
            F3_LW:   ext = sxw;
            F3_LBU:  ext = zxb;
            F3_LHU:  ext = zxh;
            F3_LWU:  ext = zxw;
            default: ext = shifted;
        endcase
    end
endmodule

// File: rtl/stage_writeback_ext.sv
// stage_writeback_ext: writeback register with stall/flush, x0 suppression and instret counter.
// Load alignment/extension is built only when STAGE_WB_LOAD_EXT_EN is defined.
module stage_writeback_ext
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64,
    localparam int OFF_W     = $clog2(XLEN / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [1:0]            mem_result_src,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       mem_read_data,
    input  logic [XLEN-1:0]       mem_instr_addr_plus,
    input  logic                  mem_regfile_wr_enable,
    input  logic [2:0]            mem_funct3,
    input  logic [OFF_W-1:0]      mem_byte_off,
    input  logic                  wb_stall,
    input  logic                  wb_flush,
    input  logic                  csr_instret_we,
    input  logic [CNT_W-1:0]      csr_instret_wdata,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_write_data,
    output logic                  wb_regfile_wr_enable,
    output logic [CNT_W-1:0]      wb_instret
);
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;
    logic            capture;

`ifdef STAGE_WB_LOAD_EXT_EN
    wb_load_ext #(.XLEN(XLEN)) u_load_ext (
        .data   (mem_read_data),
        .funct3 (mem_funct3),
        .off    (mem_byte_off),
        .ext    (load_data)
    );
`else
    // Alignment lives in the memory stage in this build.
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{mem_funct3, mem_byte_off};
    assign load_data = mem_read_data;
`endif

    always_comb begin
        capture = !wb_stall && !wb_flush;
        result  = (mem_result_src == RES_MEM)     ? load_data :
                  (mem_result_src == RES_PC_PLUS) ? mem_instr_addr_plus : mem_alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid             <= 1'b0;
            wb_rd                <= '0;
            wb_write_data        <= '0;
            wb_regfile_wr_enable <= 1'b0;
            wb_instret           <= '0;
        end else begin
            if (wb_flush) begin
                wb_valid             <= 1'b0;
                wb_regfile_wr_enable <= 1'b0;
            end else if (!wb_stall) begin
                wb_valid             <= mem_valid;
                wb_rd                <= mem_rd;
                wb_write_data        <= result;
                wb_regfile_wr_enable <= mem_valid && mem_regfile_wr_enable && (mem_rd != '0);
            end
            // A CSR write overrides a same-cycle retirement.
            if (csr_instret_we)
                wb_instret <= csr_instret_wdata;
            else if (capture && mem_valid)
                wb_instret <= wb_instret + CNT_W'(1);
        end
    end
endmodule
